// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner: debounce FSM
// states, matrix dimensions, the key map and the scan-result encoding.
// A scan result is 5 bits: bit 4 set means "exactly one key closed" and
// bits 3:0 carry its hex code. SCAN_NONE means no key or several keys.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } state_e;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  // Pmod KYPD layout, indexed by {row, col}.
  localparam logic [0:15][3:0] KEY_MAP = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  localparam logic [4:0] SCAN_NONE = 5'b0_0000;

  // Hex code of the key at the given row/column crossing.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c}];
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a bus of independent asynchronous level inputs.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, flops load RST_VAL
//   d_i   - asynchronous input bus
//   q_o   - synchronized output bus (two clk cycles of latency)
module sync_2ff #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture; the first stage may go metastable, the second settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, forms one
// result per full scan (a single closed key, or NONE), and debounces those
// results into accepted presses and releases.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   row_i       - keypad rows, active-low, asynchronous to clk
//   col_o       - keypad column drive, active-low, one column low at a time
//   key_o       - hex code of the last accepted key
//   key_valid_o - one-cycle pulse when a new press is accepted
//   key_held_o  - high from press acceptance until release acceptance
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int              SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam int              CW        = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  // Value of cnt at which one more match completes the debounce.
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_SCANS - 1);

  // Column sequencer
  logic [SW-1:0]         slot_q, slot_d;
  logic [1:0]            col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0]   col_q, col_d;

  // Scan accumulator: hits saturate at 2, meaning "more than one"
  logic [1:0]            hits_q, hits_d;
  logic [3:0]            code_q, code_d;

  // Debounce FSM and outputs
  state_e                state_q, state_d;
  logic [3:0]            cand_q, cand_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            key_q, key_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q, key_held_d;

  logic [NUM_ROWS-1:0]   row_sync;
  logic                  sample;
  logic                  scan_end;
  logic [2:0]            col_cnt;
  logic [3:0]            col_code;
  logic [2:0]            tot;
  logic [1:0]            tot_sat;
  logic [3:0]            merged_code;
  logic [4:0]            result;

  sync_2ff #(
    .WIDTH   (NUM_ROWS),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row_i),
    .q_o   (row_sync)
  );

  assign sample   = (slot_q == SLOT_LAST);
  assign scan_end = sample && (col_idx_q == 2'd3);

  // Slot counter and column rotation; column advances when the slot wraps.
  always_comb begin
    slot_d    = slot_q + SW'(1);
    col_idx_d = col_idx_q;
    col_d     = col_q;
    if (sample) begin
      slot_d    = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
    end else begin
      col_idx_d = col_idx_q;
    end
  end

  // Closures seen in the active column and the code of the last one found.
  always_comb begin
    col_cnt  = 3'd0;
    col_code = 4'h0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync[r]) begin
        col_cnt  = col_cnt + 3'd1;
        col_code = key_code(2'(r), col_idx_q);
      end else begin
        col_cnt  = col_cnt;
      end
    end
  end

  // Merge this column into the running scan; the code only matters while
  // exactly one closure has been seen, so it is taken from the first column
  // that reported any.
  always_comb begin
    tot         = {1'b0, hits_q} + col_cnt;
    tot_sat     = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    merged_code = (hits_q == 2'd0) ? col_code : code_q;
    result      = (tot_sat == 2'd1) ? {1'b1, merged_code} : SCAN_NONE;
  end

  // Accumulator update; cleared after the column-3 sample starts a new scan.
  always_comb begin
    hits_d = hits_q;
    code_d = code_q;
    if (sample) begin
      if (col_idx_q == 2'd3) begin
        hits_d = 2'd0;
        code_d = 4'h0;
      end else begin
        hits_d = tot_sat;
        code_d = merged_code;
      end
    end else begin
      hits_d = hits_q;
    end
  end

  // Debounce FSM, advanced once per completed scan result.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (result[4]) begin
            cand_d = result[3:0];
            if (DEBOUNCE_SCANS == 1) begin
              state_d     = HELD;
              key_d       = result[3:0];
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
            end else begin
              state_d = PRESS_PEND;
              cnt_d   = CNT_ONE;
            end
          end else begin
            cnt_d = '0;
          end
        end
        PRESS_PEND: begin
          if (result == {1'b1, cand_q}) begin
            if (cnt_q == CNT_LAST) begin
              state_d     = HELD;
              key_d       = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (result[4]) begin
            cand_d = result[3:0];
            cnt_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (result == {1'b1, key_q}) begin
            state_d = HELD;
          end else if (DEBOUNCE_SCANS == 1) begin
            state_d    = IDLE;
            key_held_d = 1'b0;
            cnt_d      = '0;
          end else begin
            state_d = RELEASE_PEND;
            cnt_d   = CNT_ONE;
          end
        end
        RELEASE_PEND: begin
          if (result != {1'b1, key_q}) begin
            if (cnt_q == CNT_LAST) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            // Contact came back before release was confirmed: no new pulse.
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          key_held_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers for sequencer, accumulator, FSM and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      hits_q      <= 2'd0;
      code_q      <= 4'h0;
      state_q     <= IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      hits_q      <= hits_d;
      code_q      <= code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_o       = col_q;
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Self-checking bench: a keypad model closes row/column crossings, the
// stimulus process pushes expected key codes into a scoreboard queue and a
// monitor pops and compares them whenever key_valid is seen.
module tb_keypad_scanner;

  localparam int SD   = 8;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;
  localparam int LAT  = 4 * SCAN + 3;

  // Key positions, index = row*4 + col
  localparam int P1 = 0;
  localparam int PA = 3;
  localparam int P5 = 5;
  localparam int P9 = 10;
  localparam int PD = 15;

  typedef struct {
    logic [3:0] key;
    int         start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [3:0]  key_o;
  logic        key_valid_o;
  logic        key_held_o;
  logic [15:0] pressed = '0;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   cycle  = 0;
  exp_t exp_q[$];

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .key_held_o  (key_held_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Keypad matrix: a row reads low when a closed key sits on a driven-low column.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(input logic [3:0] k);
    exp_t e;
    e.key   = k;
    e.start = cycle;
    exp_q.push_back(e);
  endtask

  task automatic wait_pulses(input int target, input string nm);
    int n = 0;
    while (pulses < target && n < LAT + 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(pulses), 32'(target));
  endtask

  task automatic wait_held(input logic v, input string nm);
    int n = 0;
    while (key_held_o !== v && n < LAT + 10) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(key_held_o), 32'(v));
  endtask

  task automatic seek_col(input logic [3:0] c, input string nm);
    int n = 0;
    while (col_o !== c && n < 2 * SCAN) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(col_o), 32'(c));
  endtask

  // Monitor: compare every key_valid pulse against the scoreboard.
  initial begin
    exp_t e;
    logic kv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        kv_prev = 1'b0;
      end else begin
        if (key_valid_o) begin
          pulses++;
          if (kv_prev) check("kv_two_cycles", 32'(kv_prev), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: key_valid with key 0x%0h, no press pending", key_o);
          end else begin
            e = exp_q.pop_front();
            check("pulse_key", 32'(key_o), 32'(e.key));
            checks++;
            if (cycle - e.start > LAT) begin
              errors++;
              $display("FAIL pulse_latency: got %0d cycles, limit %0d", cycle - e.start, LAT);
            end
          end
        end
        kv_prev = key_valid_o;
      end
    end
  end

  // Stimulus
  initial begin
    int   base;
    logic held_min;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_col", 32'(col_o), 32'h0000_000E);
    check("rst_key", 32'(key_o), 32'd0);
    check("rst_kv", 32'(key_valid_o), 32'd0);
    check("rst_held", 32'(key_held_o), 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(20);

    // Clean press of 5
    pressed[P5] = 1'b1;
    expect_key(4'h5);
    wait_pulses(1, "clean_pulse");
    check("clean_key", 32'(key_o), 32'h5);
    check("clean_held", 32'(key_held_o), 32'd1);
    cycles(10 * SCAN);
    check("clean_held_long", 32'(key_held_o), 32'd1);
    check("clean_single_pulse", 32'(pulses), 32'd1);
    pressed = '0;
    wait_held(1'b0, "clean_release");
    check("clean_key_kept", 32'(key_o), 32'h5);
    cycles(SCAN);

    // Glitchy release of 5
    pressed[P5] = 1'b1;
    expect_key(4'h5);
    wait_pulses(2, "glitch_press_pulse");
    cycles(2 * SCAN);
    held_min = 1'b1;
    pressed[P5] = 1'b0;
    repeat (2 * SCAN) begin
      @(negedge clk);
      if (!key_held_o) held_min = 1'b0;
    end
    pressed[P5] = 1'b1;
    repeat (4 * SCAN) begin
      @(negedge clk);
      if (!key_held_o) held_min = 1'b0;
    end
    check("glitch_held", 32'(held_min), 32'd1);
    check("glitch_no_pulse", 32'(pulses), 32'd2);

    // Asynchronous reset mid-scan while held
    seek_col(4'b1011, "seek_col2");
    pressed = '0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_col", 32'(col_o), 32'h0000_000E);
    check("arst_key", 32'(key_o), 32'd0);
    check("arst_kv", 32'(key_valid_o), 32'd0);
    check("arst_held", 32'(key_held_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(SCAN);

    // Bouncing contact on D, then stable
    base = pulses;
    for (int i = 0; i < 12; i++) begin
      pressed[PD] = ~pressed[PD];
      cycles(5);
    end
    pressed[PD] = 1'b1;
    expect_key(4'hD);
    wait_pulses(base + 1, "bounce_pulse");
    check("bounce_key", 32'(key_o), 32'hD);
    cycles(20 * SCAN);
    check("bounce_single_pulse", 32'(pulses), 32'(base + 1));
    check("bounce_held", 32'(key_held_o), 32'd1);
    pressed = '0;
    wait_held(1'b0, "bounce_release");

    // Multi-key: 1 and 9 together, then 1 alone, then 9 added, then 9 alone
    base = pulses;
    pressed[P1] = 1'b1;
    pressed[P9] = 1'b1;
    cycles(10 * SCAN);
    check("multi_no_pulse", 32'(pulses), 32'(base));
    check("multi_not_held", 32'(key_held_o), 32'd0);
    pressed[P9] = 1'b0;
    expect_key(4'h1);
    wait_pulses(base + 1, "multi_key1_pulse");
    check("multi_key1", 32'(key_o), 32'h1);
    pressed[P9] = 1'b1;
    wait_held(1'b0, "multi_add9_drop");
    cycles(5 * SCAN);
    check("multi_no_pulse_9", 32'(pulses), 32'(base + 1));
    pressed[P1] = 1'b0;
    expect_key(4'h9);
    wait_pulses(base + 2, "multi_key9_pulse");
    check("multi_key9", 32'(key_o), 32'h9);
    pressed = '0;
    wait_held(1'b0, "multi_release");

    // Reset during PRESS_PEND for A after two matching scans
    seek_col(4'b0111, "pend_seek_c3");
    seek_col(4'b1110, "pend_seek_c0");
    pressed[PA] = 1'b1;
    seek_col(4'b0111, "pend_scan1_c3");
    seek_col(4'b1110, "pend_scan1_end");
    seek_col(4'b0111, "pend_scan2_c3");
    seek_col(4'b1110, "pend_scan2_end");
    #2 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    base = pulses;
    expect_key(4'hA);
    cycles(80);
    check("pend_rst_no_early_pulse", 32'(pulses), 32'(base));
    wait_pulses(base + 1, "pend_rst_pulse");
    check("pend_rst_key", 32'(key_o), 32'hA);
    pressed = '0;
    wait_held(1'b0, "pend_rst_release");
    cycles(SCAN);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
